// File: rtl/ext_pkg.sv
// Mode encodings shared by the operand extender pipeline and its lane extender.
package ext_pkg;
  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO    = 2'b00;
  localparam ext_mode_t EXT_SIGN    = 2'b01;
  localparam ext_mode_t EXT_ZERO_AL = 2'b10;
  localparam ext_mode_t EXT_SIGN_AL = 2'b11;
endpackage

// File: rtl/ext_lane.sv
// Combinational single-lane extender: zero/sign extension with optional left-align shift.
module ext_lane
  import ext_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 8,
  parameter int ALIGN_SH = 2
) (
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  logic signed [IN_W-1:0]  in_s;
  logic signed [OUT_W-1:0] sx;
  logic        [OUT_W-1:0] zx;
  logic        [OUT_W-1:0] ext;
  logic                    use_sign;
  logic                    use_align;

  assign in_s      = in;
  assign sx        = OUT_W'(in_s);
  assign zx        = OUT_W'(in);
  assign use_sign  = (mode == EXT_SIGN) || (mode == EXT_SIGN_AL);
  assign use_align = (mode == EXT_ZERO_AL) || (mode == EXT_SIGN_AL);
  assign ext       = use_sign ? sx : zx;
  // Headroom is guaranteed by OUT_W >= IN_W + ALIGN_SH, so the shift never drops data bits.
  assign out       = use_align ? (ext << ALIGN_SH) : ext;

endmodule

// File: rtl/ext_align_pipe.sv
// Multi-lane operand extender with a registered output and 2-entry skid buffer.
// Optional per-lane even parity output is enabled by defining EXT_PARITY_EN.
module ext_align_pipe
  import ext_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 8,
  parameter int LANES    = 2,
  parameter int ALIGN_SH = 2,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]       txn_cnt
`ifdef EXT_PARITY_EN
  ,
  output logic [LANES-1:0]       out_par
`endif
);

  if (OUT_W < IN_W + ALIGN_SH) begin : g_bad_width
    $error("ext_align_pipe: OUT_W must be >= IN_W + ALIGN_SH");
  end
  if (IN_W < 2) begin : g_bad_in_w
    $error("ext_align_pipe: IN_W must be >= 2");
  end

  ext_mode_t               mode_p0;
  logic [LANES*OUT_W-1:0]  data_p0;
  logic [LANES*OUT_W-1:0]  data_p1;
  logic [LANES*OUT_W-1:0]  skid_data;
  logic                    vld_p1;
  logic                    skid_vld;
  logic                    accept;
  logic                    out_hs;
  logic                    out_free;
  logic [CNT_W-1:0]        cnt;

  assign mode_p0 = ext_mode_t'(in_mode);

  // Stage p0: combinational extension of every lane on the input side
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ext_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .ALIGN_SH(ALIGN_SH)
    ) u_lane (
      .mode(mode_p0),
      .in  (in_data[k*IN_W +: IN_W]),
      .out (data_p0[k*OUT_W +: OUT_W])
    );
  end

  // Ready depends only on registered state and reset, never on out_ready.
  assign in_ready  = !skid_vld && !rst;
  assign accept    = in_valid && in_ready;
  assign out_hs    = vld_p1 && out_ready;
  assign out_free  = !vld_p1 || out_ready;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign txn_cnt   = cnt;

  // Stage p1: output register with skid buffer behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      skid_vld  <= 1'b0;
      data_p1   <= '0;
      skid_data <= '0;
      cnt       <= '0;
    end else begin
      if (out_free) begin
        if (skid_vld) begin
          data_p1  <= skid_data;
          vld_p1   <= 1'b1;
          skid_vld <= 1'b0;
        end else if (accept) begin
          data_p1 <= data_p0;
          vld_p1  <= 1'b1;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= data_p0;
        skid_vld  <= 1'b1;
      end
      if (out_hs) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef EXT_PARITY_EN
  logic [LANES-1:0] par_p0;
  logic [LANES-1:0] par_p1;
  logic [LANES-1:0] skid_par;

  always_comb begin
    par_p0 = '0;
    for (int k = 0; k < LANES; k++) par_p0[k] = ^data_p0[k*OUT_W +: OUT_W];
  end

  // Parity follows exactly the same load decisions as the data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_p1   <= '0;
      skid_par <= '0;
    end else if (out_free) begin
      if (skid_vld)    par_p1 <= skid_par;
      else if (accept) par_p1 <= par_p0;
    end else if (accept) begin
      skid_par <= par_p0;
    end
  end

  assign out_par = par_p1;
`endif

endmodule
